// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller definitions: command encodings, idle bus values and
// address field helpers used by the read engine, write engine and arbiter.
package sdram_ctrl_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  localparam logic [1:0]  BA_IDLE      = 2'b11;
  localparam logic [12:0] ADDR_IDLE    = 13'h1fff;
  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

  typedef struct packed {
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
  } sdram_addr_t;

  function automatic logic [12:0] col_to_addr(input logic [8:0] col);
    return {4'b0000, col};
  endfunction

endpackage

// File: rtl/sdram_burst_rd.sv
// SDRAM read-path engine: ACTIVE, full-page READ truncated by BURST_STOP,
// CAS-latency-aligned data capture, then PRECHARGE all banks.
module sdram_burst_rd
  import sdram_ctrl_pkg::*;
#(
  parameter int unsigned TRCD    = 2,
  parameter int unsigned TRP     = 2,
  parameter int unsigned CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] sdram_dq,
  output logic [3:0]  rd_cmd,
  output logic [1:0]  rd_ba,
  output logic [12:0] rd_sdram_addr,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic        rd_end,
  output logic        rd_busy
);

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_ACTIVE = 8'b0000_0010,
    S_TRCD   = 8'b0000_0100,
    S_READ   = 8'b0000_1000,
    S_DATA   = 8'b0001_0000,
    S_PRE    = 8'b0010_0000,
    S_TRP    = 8'b0100_0000,
    S_END    = 8'b1000_0000
  } state_t;

  localparam logic [9:0] CL10      = 10'(CAS_LAT);
  localparam logic [9:0] TRCD_LAST = 10'(TRCD - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP - 1);

  state_t      state;
  logic [9:0]  cnt;
  sdram_addr_t addr_q;
  logic [9:0]  len_q;

  logic [9:0]  stop_cnt;
  logic [9:0]  data_last;
  logic        capture;

  // Word j leaves the DQ pins at DATA count CAS_LAT+j, so the capture window
  // is offset from the command window by exactly the CAS latency.
  assign stop_cnt  = len_q - 10'd1;
  assign data_last = len_q + CL10 - 10'd1;
  assign capture   = (cnt >= CL10) && (cnt <= data_last);

  assign rd_end  = (state == S_END);
  assign rd_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      rd_cmd        <= CMD_NOP;
      rd_ba         <= BA_IDLE;
      rd_sdram_addr <= ADDR_IDLE;
      rd_data       <= '0;
      rd_ack        <= 1'b0;
    end else begin
      rd_cmd        <= CMD_NOP;
      rd_ba         <= BA_IDLE;
      rd_sdram_addr <= ADDR_IDLE;
      rd_ack        <= 1'b0;
      cnt           <= cnt + 10'd1;

      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (init_end && rd_en) begin
            addr_q <= rd_addr;
            len_q  <= rd_burst_len;
            state  <= S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          rd_cmd        <= CMD_ACTIVE;
          rd_ba         <= addr_q.bank;
          rd_sdram_addr <= addr_q.row;
          cnt           <= '0;
          state         <= S_TRCD;
        end

        S_TRCD: begin
          if (cnt == TRCD_LAST) begin
            cnt   <= '0;
            state <= S_READ;
          end
        end

        S_READ: begin
          rd_cmd        <= CMD_READ;
          rd_ba         <= addr_q.bank;
          rd_sdram_addr <= col_to_addr(addr_q.col);
          cnt           <= '0;
          state         <= S_DATA;
        end

        S_DATA: begin
          // BURST_STOP leaves ba/addr as they were on the previous cycle.
          if (cnt == stop_cnt) begin
            rd_cmd        <= CMD_BURST_STOP;
            rd_ba         <= rd_ba;
            rd_sdram_addr <= rd_sdram_addr;
          end
          if (capture) begin
            rd_ack  <= 1'b1;
            rd_data <= sdram_dq;
          end
          if (cnt == data_last) begin
            cnt   <= '0;
            state <= S_PRE;
          end
        end

        S_PRE: begin
          rd_cmd        <= CMD_PRECHARGE;
          rd_ba         <= addr_q.bank;
          rd_sdram_addr <= ADDR_PRE_ALL;
          cnt           <= '0;
          state         <= S_TRP;
        end

        S_TRP: begin
          if (cnt == TRP_LAST) begin
            cnt   <= '0;
            state <= S_END;
          end
        end

        S_END: begin
          cnt   <= '0;
          state <= S_IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_rd.sv
// Directed and randomized bench for sdram_burst_rd with a page-mode SDRAM
// model answering on the DQ bus and a cycle-indexed expectation per transaction.
module tb_sdram_burst_rd;

  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int CL   = 3;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_BST  = 4'b0110;
  localparam logic [3:0] C_PRE  = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] sdram_dq = 16'hdead;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_sdram_addr;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        rd_end;
  logic        rd_busy;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_data = '0;

  sdram_burst_rd #(.TRCD(TRCD), .TRP(TRP), .CAS_LAT(CL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_end      (init_end),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_burst_len  (rd_burst_len),
    .sdram_dq      (sdram_dq),
    .rd_cmd        (rd_cmd),
    .rd_ba         (rd_ba),
    .rd_sdram_addr (rd_sdram_addr),
    .rd_data       (rd_data),
    .rd_ack        (rd_ack),
    .rd_end        (rd_end),
    .rd_busy       (rd_busy)
  );

  always #5 clk = ~clk;

  // Memory contents: low 9 bits are the column index, upper bits tag bank/row.
  function automatic logic [15:0] mem_word(input logic [1:0] b, input logic [12:0] r,
                                           input logic [8:0] c);
    return {b, r[4:0], c};
  endfunction

  // SDRAM model: tracks open rows, drives word j of a read at READ+CL+j until
  // the burst is stopped (BURST_STOP at cycle S ends output after S+CL-1).
  int          cyc = 0;
  logic [12:0] open_row [4];
  int          m_start = -100000;
  int          m_stop  = 0;
  logic [1:0]  m_bank;
  logic [8:0]  m_col;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int j;
    if (!rst_n) begin
      m_start  = -100000;
      sdram_dq = 16'hdead;
    end else begin
      case (rd_cmd)
        C_ACT: open_row[rd_ba] = rd_sdram_addr;
        C_RD: begin
          m_start = cyc;
          m_stop  = cyc + 100000;
          m_bank  = rd_ba;
          m_col   = rd_sdram_addr[8:0];
        end
        C_BST: m_stop = cyc;
        default: ;
      endcase
      j = cyc - m_start - CL;
      if (j >= 0 && (m_start + j) < m_stop)
        sdram_dq = mem_word(m_bank, open_row[m_bank], 9'((int'(m_col) + j) % 512));
      else
        sdram_dq = 16'hdead;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd"},  32'(rd_cmd), 32'(C_NOP));
    chk({tag, "_ba"},   32'(rd_ba), 32'h3);
    chk({tag, "_addr"}, 32'(rd_sdram_addr), 32'h1fff);
    chk({tag, "_ack"},  32'(rd_ack), 32'h0);
    chk({tag, "_busy"}, 32'(rd_busy), 32'h0);
    chk({tag, "_end"},  32'(rd_end), 32'h0);
  endtask

  // mode 0: rd_en pulse; 1: rd_en held high to the end; 2: inputs disturbed
  // while busy; 3: init_end dropped mid-transaction. abort_at>0 asserts reset
  // in that cycle. Cycle 0 is the grant cycle; ACTIVE is on the bus at cycle 2.
  task automatic run_txn(input logic [23:0] a, input int len, input int mode,
                         input int abort_at);
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    int R, P, E;
    logic [3:0]  ec;
    logic [1:0]  eba;
    logic [12:0] ea;
    logic        eack;
    bank = a[23:22];
    row  = a[21:9];
    col  = a[8:0];
    R = TRCD + 3;
    P = R + len + CL;
    E = P + 1 + TRP;

    @(negedge clk);
    chk("pre_busy", 32'(rd_busy), 32'h0);
    chk("pre_cmd", 32'(rd_cmd), 32'(C_NOP));
    chk("pre_data", 32'(rd_data), 32'(exp_data));
    rd_addr      = a;
    rd_burst_len = 10'(len);
    rd_en        = 1'b1;

    for (int c = 1; c <= E; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_data = '0;
        chk_idle("rst");
        chk("rst_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        chk_idle("rst_hold");
        rst_n = 1'b1;
        rd_en = 1'b0;
        return;
      end
      ec = C_NOP; eba = 2'b11; ea = 13'h1fff;
      if (c == 2)       begin ec = C_ACT; eba = bank; ea = row; end
      if (c == R)       begin ec = C_RD;  eba = bank; ea = {4'b0, col}; end
      if (c == R + len) begin
        ec = C_BST;
        if (len == 1) begin eba = bank; ea = {4'b0, col}; end
      end
      if (c == P + 1)   begin ec = C_PRE; eba = bank; ea = 13'h0400; end
      eack = (c >= R + CL + 1) && (c <= R + CL + len);
      if (eack)
        exp_data = mem_word(bank, row, 9'((int'(col) + (c - R - CL - 1)) % 512));
      chk("cmd",  32'(rd_cmd), 32'(ec));
      chk("ba",   32'(rd_ba), 32'(eba));
      chk("addr", 32'(rd_sdram_addr), 32'(ea));
      chk("ack",  32'(rd_ack), 32'(eack));
      chk("data", 32'(rd_data), 32'(exp_data));
      chk("busy", 32'(rd_busy), 32'h1);
      chk("end",  32'(rd_end), 32'(c == E));

      if (c == 1 && mode != 1) rd_en = 1'b0;
      if (mode == 2 && c == 3) begin
        rd_addr      = 24'($urandom);
        rd_burst_len = 10'($urandom_range(1, 512));
        rd_en        = 1'b1;
      end
      if (mode == 2 && c == 4) rd_en = 1'b0;
      if (mode == 3 && c == 3) init_end = 1'b0;
      if (mode == 3 && c == R + 2) init_end = 1'b1;
    end
  endtask

  function automatic logic [23:0] rand_addr();
    return {2'($urandom), 13'($urandom_range(0, 31)), 9'($urandom)};
  endfunction

  initial begin
    rst_n        = 1'b0;
    init_end     = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    rd_burst_len = 10'd1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_data", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle("noinit");
    end
    rd_en    = 1'b0;
    init_end = 1'b1;

    run_txn(24'h40_0A05, 8, 0, -1);
    run_txn(24'h00_0000, 1, 0, -1);
    run_txn(24'h00_0000, 512, 0, -1);
    run_txn(rand_addr(), 5, 2, -1);
    run_txn(rand_addr(), 10, 3, -1);
    run_txn(rand_addr(), 3, 1, -1);
    run_txn(rand_addr(), 2, 1, -1);
    run_txn(rand_addr(), 4, 0, -1);
    run_txn({2'b10, 13'd7, 9'd505}, 20, 0, -1);
    for (int i = 0; i < 6; i++)
      run_txn(rand_addr(), int'($urandom_range(1, 40)), 0, -1);
    run_txn(rand_addr(), 16, 0, TRCD + 3 + CL + 3);
    run_txn(rand_addr(), 6, 0, -1);

    repeat (2) @(negedge clk);
    chk_idle("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
